// File: rtl/color_reduce_wr.sv
// color_reduce_wr: captures whole visible frames from the bank 0 two-pixel read
// stream, reduces each 6-bit colour channel to a selectable depth and writes the
// reduced pixel pairs to ZBT bank 1 through a two-stage pipeline.
//
// Ports:
//   clk, reset        pixel clock; asynchronous active-low reset
//   hcount, vcount    raster position of the current pixel pair
//   two_pixel_data    pixel pair, [35:18] even x, [17:0] odd x, each R/G/B 6 bits
//   write_addr1       bank 1 address for the pair
//   bits_sel          channel depth 0:6, 1:4, 2:3, 3:2 bits (latched per frame)
//   capture           one-cycle request to capture the next frame
//   continuous        re-arm automatically at the end of each frame
//   vram_write_data   reduced pixel pair
//   vram_addr1        bank 1 write address
//   vram_we1          one-cycle write strobe
//   busy              high while armed or writing
//   frame_done        one-cycle pulse at the end of a captured frame
//   wr_count          pair writes in the current or last frame
//
// Optional feature: define COLOR_REDUCE_DITHER_EN to add a 2x2 ordered (Bayer)
// dither ahead of truncation.
module color_reduce_wr #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned V_ACTIVE = 768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [35:0] two_pixel_data,
    input  logic [18:0] write_addr1,
    input  logic [1:0]  bits_sel,
    input  logic        capture,
    input  logic        continuous,
    output logic [35:0] vram_write_data,
    output logic [18:0] vram_addr1,
    output logic        vram_we1,
    output logic        busy,
    output logic        frame_done,
    output logic [18:0] wr_count
);
    localparam logic [10:0] HActive = 11'(H_ACTIVE);
    localparam logic [9:0]  VActive = 10'(V_ACTIVE);

    typedef enum logic [1:0] {StIdle, StArmed, StWrite} state_e;

    state_e      state_q, state_d;
    logic [1:0]  depth_q, depth_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [18:0] wr_count_q, wr_count_d;
    logic        s1_valid_q, s1_valid_d;
    logic [35:0] s1_data_q, s1_data_d;
    logic [18:0] s1_addr_q, s1_addr_d;
    logic        s2_we_q, s2_we_d;
    logic [35:0] s2_data_q, s2_data_d;
    logic [18:0] s2_addr_q, s2_addr_d;
    logic        sample;
    logic [5:0]  chan;
    logic [35:0] reduced;
`ifdef COLOR_REDUCE_DITHER_EN
    logic        s1_y0_q, s1_y0_d;
`endif

    // Keep the top N bits and refill the low bits by repeating them MSB-first.
    function automatic logic [5:0] quantize(input logic [5:0] v, input logic [1:0] sel);
        logic [5:0] r;
        case (sel)
            2'd0:    r = v;
            2'd1:    r = {v[5:2], v[5:4]};
            2'd2:    r = {v[5:3], v[5:3]};
            default: r = {3{v[5:4]}};
        endcase
        return r;
    endfunction

`ifdef COLOR_REDUCE_DITHER_EN
    // Adds (d << (6-N)) >> 2 with d from the 2x2 Bayer matrix, saturating at 63.
    function automatic logic [5:0] dither(input logic [5:0] v, input logic [1:0] sel,
                                          input logic y0, input logic x0);
        logic [1:0] d;
        logic [5:0] off;
        logic [6:0] sum;
        case ({y0, x0})
            2'b00:   d = 2'd0;
            2'b01:   d = 2'd2;
            2'b10:   d = 2'd3;
            default: d = 2'd1;
        endcase
        case (sel)
            2'd0:    off = 6'd0;
            2'd1:    off = {4'd0, d};
            2'd2:    off = {3'd0, d, 1'b0};
            default: off = {2'd0, d, 2'd0};
        endcase
        sum = {1'b0, v} + {1'b0, off};
        return sum[6] ? 6'd63 : sum[5:0];
    endfunction
`endif

    // Capture FSM and frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        frame_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (capture) state_d = StArmed;
            end
            StArmed: begin
                if (hcount == 11'd0 && vcount == 10'd0) begin
                    state_d = StWrite;
                    depth_d = bits_sel;
                end
            end
            StWrite: begin
                // capture is deliberately not looked at here; only continuous re-arms
                if (hcount == 11'd0 && vcount == VActive) begin
                    state_d      = continuous ? StArmed : StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);

        if (state_q == StArmed && state_d == StWrite) begin
            wr_count_d = 19'd0;
        end else if (s2_we_q) begin
            wr_count_d = wr_count_q + 19'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Stage 1: one sample per pair, taken on the odd pixel of the visible area.
    assign sample = (state_q == StWrite) && hcount[0] && (hcount < HActive) &&
                    (vcount < VActive);

    always_comb begin
        s1_valid_d = sample;
        s1_data_d  = sample ? two_pixel_data : s1_data_q;
        s1_addr_d  = sample ? write_addr1 : s1_addr_q;
`ifdef COLOR_REDUCE_DITHER_EN
        s1_y0_d    = sample ? vcount[0] : s1_y0_q;
`endif
    end

    // Stage 2: per-channel reduction. Channels 0..2 belong to the odd pixel (x0 = 1).
    always_comb begin
        chan    = 6'd0;
        reduced = 36'd0;
        for (int i = 0; i < 6; i++) begin
            chan = s1_data_q[i*6 +: 6];
`ifdef COLOR_REDUCE_DITHER_EN
            chan = dither(chan, depth_q, s1_y0_q, (i < 3));
`endif
            reduced[i*6 +: 6] = quantize(chan, depth_q);
        end
        s2_we_d   = s1_valid_q;
        s2_data_d = s1_valid_q ? reduced : s2_data_q;
        s2_addr_d = s1_valid_q ? s1_addr_q : s2_addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            depth_q      <= 2'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wr_count_q   <= 19'd0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= 36'd0;
            s1_addr_q    <= 19'd0;
            s2_we_q      <= 1'b0;
            s2_data_q    <= 36'd0;
            s2_addr_q    <= 19'd0;
`ifdef COLOR_REDUCE_DITHER_EN
            s1_y0_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            wr_count_q   <= wr_count_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_addr_q    <= s1_addr_d;
            s2_we_q      <= s2_we_d;
            s2_data_q    <= s2_data_d;
            s2_addr_q    <= s2_addr_d;
`ifdef COLOR_REDUCE_DITHER_EN
            s1_y0_q      <= s1_y0_d;
`endif
        end
    end

    assign vram_write_data = s2_data_q;
    assign vram_addr1      = s2_addr_q;
    assign vram_we1        = s2_we_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign wr_count        = wr_count_q;

endmodule
